// File: rtl/mem_stage_sb_if.sv
// Data-cache request/response bus between mem_stage_sb (master) and the dcache (slave).
interface mem_stage_sb_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic                  dc_req;
  logic                  dc_we;
  logic [ADDR_W-1:0]     dc_addr;
  logic [DATA_W-1:0]     dc_wdata;
  logic [DATA_W/8-1:0]   dc_wmask;
  logic [DATA_W-1:0]     dc_rdata;
  logic                  dc_done;

  modport master (output dc_req, dc_we, dc_addr, dc_wdata, dc_wmask, input dc_rdata, dc_done);
  modport slave  (input dc_req, dc_we, dc_addr, dc_wdata, dc_wmask, output dc_rdata, dc_done);
endinterface

// File: rtl/mem_stage_sb.sv
// Memory stage with store buffer, sized/aligned accesses and one outstanding dcache request.
// Store-to-load forwarding is enabled by defining MEM_STORE_FWD_EN.
module mem_stage_sb #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 64,
  parameter int RES_W    = 128,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_size,
  input  logic              in_sext,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [RES_W-1:0]  in_pass,
  output logic              out_valid,
  output logic [RES_W-1:0]  out_result,
  output logic              out_misalign,
  mem_stage_sb_if.master    dc
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [ADDR_W-1:0]   sb_addr_reg [SB_DEPTH];
  logic [DATA_W-1:0]   sb_data_reg [SB_DEPTH];
  logic [BYTES-1:0]    sb_mask_reg [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_valid_reg;
  logic [PTR_W-1:0]    head_reg, tail_reg;
  logic [CNT_W-1:0]    count_reg;

  logic              out_valid_reg, out_misalign_reg;
  logic [RES_W-1:0]  out_result_reg;
  logic              dc_req_reg, dc_we_reg;
  logic [ADDR_W-1:0] dc_addr_reg;
  logic [DATA_W-1:0] dc_wdata_reg;
  logic [BYTES-1:0]  dc_wmask_reg;
  logic [OFF_W-1:0]  ld_off_reg;
  logic [1:0]        ld_size_reg;
  logic              ld_sext_reg;

  // Lane-extract a sized field from a data word and sign/zero extend it.
  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] d,
                                                input logic [OFF_W-1:0] off_i,
                                                input logic [1:0] size_i,
                                                input logic sext_i);
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] r;
    logic sign;
    s = d >> {off_i, 3'b000};
    sign = 1'b0;
    for (int i = 0; i < BYTES; i++)
      if (i == (1 << size_i) - 1) sign = s[8*i+7];
    for (int i = 0; i < BYTES; i++)
      r[8*i +: 8] = (i < (1 << size_i)) ? s[8*i +: 8] : {8{sext_i & sign}};
    return r;
  endfunction

  logic              op_load, op_store, misalign;
  logic [OFF_W-1:0]  off;
  logic [4:0]        span;
  logic [ADDR_W-1:0] word_addr;
  logic [BYTES-1:0]  base_mask, acc_mask;
  logic [DATA_W-1:0] acc_wdata;
  logic [SB_DEPTH-1:0] match;
  logic              fwd_ok;
  logic [DATA_W-1:0] fwd_data;

  assign op_load   = (in_op == 2'd1);
  assign op_store  = (in_op == 2'd2);
  assign off       = in_addr[OFF_W-1:0];
  assign span      = 5'(off) + (5'd1 << in_size);
  assign misalign  = (op_load | op_store) & (span > 5'(BYTES));
  assign word_addr = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign acc_mask  = base_mask << off;
  assign acc_wdata = in_wdata << {off, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_mask
      assign base_mask[gi] = (32'(gi) < (32'd1 << in_size));
    end
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_match
`ifdef MEM_STORE_FWD_EN
      assign match[gi] = sb_valid_reg[gi] && (sb_addr_reg[gi] == word_addr)
                         && |(sb_mask_reg[gi] & acc_mask);
`else
      assign match[gi] = sb_valid_reg[gi] && (sb_addr_reg[gi] == word_addr);
`endif
    end
  endgenerate

`ifdef MEM_STORE_FWD_EN
  logic [PTR_W-1:0] fwd_idx, age_idx;
  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    fwd_idx = head_reg;
    age_idx = head_reg;
    for (int k = 0; k < SB_DEPTH; k++) begin
      age_idx = head_reg + PTR_W'(k);
      if (match[age_idx]) fwd_idx = age_idx;
    end
  end
  assign fwd_ok   = (|match) && ((sb_mask_reg[fwd_idx] & acc_mask) == acc_mask);
  assign fwd_data = sb_data_reg[fwd_idx];
`else
  assign fwd_ok   = 1'b0;
  assign fwd_data = '0;
`endif

  logic pop, sb_full, st_can_go, ld_can_go, accept, enq, start_load, fwd_hit;
  assign pop       = (state_reg == DRAIN) && dc.dc_done;
  assign sb_full   = (count_reg == CNT_W'(SB_DEPTH));
  assign st_can_go = misalign || !sb_full || pop;
  assign ld_can_go = misalign || !(|match) || fwd_ok;
  assign accept    = in_valid && in_ready;
  assign enq       = accept && op_store && !misalign;
  assign fwd_hit   = accept && op_load && !misalign && fwd_ok;
  assign start_load = accept && op_load && !misalign && !fwd_ok;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = op_load ? ld_can_go : (op_store ? st_can_go : 1'b1);
        if (start_load)           state_next = LOAD_WAIT;
        else if (count_reg != '0) state_next = DRAIN;
      end
      LOAD_WAIT: if (dc.dc_done) state_next = IDLE;
      DRAIN: begin
        in_ready = op_load ? 1'b0 : (op_store ? st_can_go : 1'b1);
        if (dc.dc_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer payload carries no reset; sb_valid_reg qualifies every entry.
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr_reg[tail_reg] <= word_addr;
      sb_data_reg[tail_reg] <= acc_wdata;
      sb_mask_reg[tail_reg] <= acc_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      sb_valid_reg <= '0;
      head_reg <= '0;
      tail_reg <= '0;
      count_reg <= '0;
      out_valid_reg <= 1'b0;
      out_misalign_reg <= 1'b0;
      out_result_reg <= '0;
      dc_req_reg <= 1'b0;
      dc_we_reg <= 1'b0;
      dc_addr_reg <= '0;
      dc_wdata_reg <= '0;
      dc_wmask_reg <= '0;
      ld_off_reg <= '0;
      ld_size_reg <= '0;
      ld_sext_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_valid_reg <= 1'b0;
      if (accept && (misalign || !op_load)) begin
        out_valid_reg <= 1'b1;
        out_misalign_reg <= misalign;
        out_result_reg <= misalign ? '0 : in_pass;
      end else if (fwd_hit) begin
        out_valid_reg <= 1'b1;
        out_misalign_reg <= 1'b0;
        out_result_reg <= RES_W'(extract(fwd_data, off, in_size, in_sext));
      end else if (state_reg == LOAD_WAIT && dc.dc_done) begin
        out_valid_reg <= 1'b1;
        out_misalign_reg <= 1'b0;
        out_result_reg <= RES_W'(extract(dc.dc_rdata, ld_off_reg, ld_size_reg, ld_sext_reg));
      end

      if (state_reg == IDLE) begin
        if (start_load) begin
          dc_req_reg <= 1'b1;
          dc_we_reg <= 1'b0;
          dc_addr_reg <= word_addr;
          dc_wdata_reg <= '0;
          dc_wmask_reg <= '0;
          ld_off_reg <= off;
          ld_size_reg <= in_size;
          ld_sext_reg <= in_sext;
        end else if (count_reg != '0) begin
          dc_req_reg <= 1'b1;
          dc_we_reg <= 1'b1;
          dc_addr_reg <= sb_addr_reg[head_reg];
          dc_wdata_reg <= sb_data_reg[head_reg];
          dc_wmask_reg <= sb_mask_reg[head_reg];
        end
      end else if (dc.dc_done) begin
        dc_req_reg <= 1'b0;
      end

      // Clear before set: a full-buffer pop and enqueue land on the same slot.
      if (pop) begin
        sb_valid_reg[head_reg] <= 1'b0;
        head_reg <= head_reg + 1'b1;
      end
      if (enq) begin
        sb_valid_reg[tail_reg] <= 1'b1;
        tail_reg <= tail_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(enq) - CNT_W'(pop);
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_result   = out_result_reg;
  assign out_misalign = out_misalign_reg;
  assign dc.dc_req    = dc_req_reg;
  assign dc.dc_we     = dc_we_reg;
  assign dc.dc_addr   = dc_addr_reg;
  assign dc.dc_wdata  = dc_wdata_reg;
  assign dc.dc_wmask  = dc_wmask_reg;
endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed self-checking bench for mem_stage_sb (default parameters); honours MEM_STORE_FWD_EN.
module tb_mem_stage_sb;
  localparam int DATA_W = 64, ADDR_W = 64, RES_W = 128, SB_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, in_sext;
  logic [1:0]        in_op, in_size;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [RES_W-1:0]  in_pass;
  logic              out_valid, out_misalign;
  logic [RES_W-1:0]  out_result;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dcif ();

  mem_stage_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RES_W(RES_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_size(in_size), .in_sext(in_sext), .in_wdata(in_wdata), .in_pass(in_pass),
    .out_valid(out_valid), .out_result(out_result), .out_misalign(out_misalign),
    .dc(dcif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_uop(input logic [1:0] op, input logic [63:0] addr, input logic [1:0] size,
                           input logic sext, input logic [63:0] wdata, input logic [127:0] pass);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_size = size;
    in_sext = sext; in_wdata = wdata; in_pass = pass;
  endtask

  task automatic drop_uop();
    in_valid = 1'b0; in_op = 2'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; drop_uop(); in_addr = '0; in_size = '0; in_sext = 1'b0; in_wdata = '0; in_pass = '0;
    dcif.dc_done = 1'b0; dcif.dc_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_result !== '0) begin n_fail++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
    n_checks++; if (dcif.dc_req !== 1'b0) begin n_fail++; $display("FAIL reset_dc_req: got %b expected 0", dcif.dc_req); end
    $display("reset: done");
  endtask

  task automatic test_passthrough();
    logic [127:0] pv [2];
    logic [1:0]   ov [2];
    pv[0] = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_ABCD; ov[0] = 2'd0;
    pv[1] = 128'hCAFE_0000_0000_0000_0000_0000_0000_0042; ov[1] = 2'd3;
    for (int i = 0; i < 2; i++) begin
      drive_uop(ov[i], 64'h10, 2'd3, 1'b0, 64'h0, pv[i]);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pass_in_ready[%0d]: got %b expected 1", i, in_ready); end
      tick(); drop_uop();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pass_out_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (out_result !== pv[i]) begin n_fail++; $display("FAIL pass_result[%0d]: got %h expected %h", i, out_result, pv[i]); end
      n_checks++; if (dcif.dc_req !== 1'b0) begin n_fail++; $display("FAIL pass_dc_req[%0d]: got %b expected 0", i, dcif.dc_req); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_pulse[%0d]: got %b expected 0", i, out_valid); end
      $display("passthrough op=%0d result=%h", ov[i], out_result);
    end
  endtask

  typedef struct packed {
    logic [63:0]  addr;
    logic [1:0]   size;
    logic         sext;
    logic [63:0]  rdata;
    logic [127:0] exp;
  } ld_vec_t;

  task automatic test_load();
    ld_vec_t lv [5];
    lv[0] = '{64'h1004, 2'd2, 1'b1, 64'h8000_0001_0000_0000, 128'hFFFF_FFFF_8000_0001};
    lv[1] = '{64'h1007, 2'd0, 1'b0, 64'h8000_0001_0000_0000, 128'h80};
    lv[2] = '{64'h1006, 2'd1, 1'b1, 64'h8000_0001_0000_0000, 128'hFFFF_FFFF_FFFF_8000};
    lv[3] = '{64'h1000, 2'd3, 1'b1, 64'h8123_4567_89AB_CDEF, 128'h8123_4567_89AB_CDEF};
    lv[4] = '{64'h1002, 2'd0, 1'b1, 64'h0000_0000_00F5_0000, 128'hFFFF_FFFF_FFFF_FFF5};
    for (int i = 0; i < 5; i++) begin
      drive_uop(2'd1, lv[i].addr, lv[i].size, lv[i].sext, 64'h0, 128'h0);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_in_ready[%0d]: got %b expected 1", i, in_ready); end
      tick(); drop_uop();
      n_checks++; if (dcif.dc_req !== 1'b1 || dcif.dc_we !== 1'b0) begin n_fail++; $display("FAIL load_req[%0d]: got req=%b we=%b expected req=1 we=0", i, dcif.dc_req, dcif.dc_we); end
      n_checks++; if (dcif.dc_addr !== (lv[i].addr & ~64'h7)) begin n_fail++; $display("FAIL load_addr[%0d]: got %h expected %h", i, dcif.dc_addr, lv[i].addr & ~64'h7); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL load_wait_ready[%0d]: got %b expected 0", i, in_ready); end
      tick(); tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_early_valid[%0d]: got %b expected 0", i, out_valid); end
      dcif.dc_rdata = lv[i].rdata; dcif.dc_done = 1'b1;
      tick(); dcif.dc_done = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (out_result !== lv[i].exp) begin n_fail++; $display("FAIL load_result[%0d]: got %h expected %h", i, out_result, lv[i].exp); end
      n_checks++; if (dcif.dc_req !== 1'b0) begin n_fail++; $display("FAIL load_req_drop[%0d]: got %b expected 0", i, dcif.dc_req); end
      $display("load addr=%h size=%0d sext=%b result=%h", lv[i].addr, lv[i].size, lv[i].sext, out_result);
      tick();
    end
  endtask

  task automatic test_misalign();
    logic [63:0] ma [3];
    logic [1:0]  ms [3];
    logic [1:0]  mo [3];
    ma[0] = 64'h3003; ms[0] = 2'd3; mo[0] = 2'd2;
    ma[1] = 64'h3007; ms[1] = 2'd1; mo[1] = 2'd1;
    ma[2] = 64'h3006; ms[2] = 2'd2; mo[2] = 2'd2;
    for (int i = 0; i < 3; i++) begin
      drive_uop(mo[i], ma[i], ms[i], 1'b0, 64'h1111_2222_3333_4444, 128'h5555);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mis_in_ready[%0d]: got %b expected 1", i, in_ready); end
      tick(); drop_uop();
      n_checks++; if (out_valid !== 1'b1 || out_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flags[%0d]: got valid=%b mis=%b expected 1 1", i, out_valid, out_misalign); end
      n_checks++; if (out_result !== '0) begin n_fail++; $display("FAIL mis_result[%0d]: got %h expected 0", i, out_result); end
      n_checks++; if (dcif.dc_req !== 1'b0) begin n_fail++; $display("FAIL mis_dc_req[%0d]: got %b expected 0", i, dcif.dc_req); end
      $display("misalign op=%0d addr=%h size=%0d", mo[i], ma[i], ms[i]);
    end
    // An empty buffer stays idle; a stray entry would start a drain.
    tick(); tick(); tick();
    n_checks++; if (dcif.dc_req !== 1'b0) begin n_fail++; $display("FAIL mis_no_drain: got %b expected 0", dcif.dc_req); end
  endtask

  task automatic test_sb_full();
    int waited;
    for (int i = 0; i < 5; i++) begin
      drive_uop(2'd2, 64'h4000 + 64'(i * 8), 2'd3, 1'b0, 64'hA0A0_0000_0000_0000 | 64'(i), 128'(i));
      #1;
      if (i < 4) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_accept[%0d]: got %b expected 1", i, in_ready); end
        tick();
        $display("store[%0d] addr=%h accepted", i, in_addr);
      end
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_block: got %b expected 0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold: got %b expected 0", in_ready); end
    n_checks++; if (dcif.dc_req !== 1'b1 || dcif.dc_we !== 1'b1 || dcif.dc_addr !== 64'h4000) begin n_fail++; $display("FAIL full_drain0: got req=%b we=%b addr=%h expected 1 1 4000", dcif.dc_req, dcif.dc_we, dcif.dc_addr); end
    n_checks++; if (dcif.dc_wmask !== 8'hFF || dcif.dc_wdata !== 64'hA0A0_0000_0000_0000) begin n_fail++; $display("FAIL full_drain0_data: got mask=%h data=%h expected ff a0a0000000000000", dcif.dc_wmask, dcif.dc_wdata); end
    dcif.dc_done = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_accept: got %b expected 1", in_ready); end
    tick(); dcif.dc_done = 1'b0; drop_uop();
    $display("store[4] addr=4020 accepted on pop");
    for (int j = 1; j < 5; j++) begin
      waited = 0;
      while (dcif.dc_req !== 1'b1 && waited < 8) begin tick(); waited++; end
      n_checks++; if (dcif.dc_req !== 1'b1) begin n_fail++; $display("FAIL drain_timeout[%0d]: got req=%b expected 1", j, dcif.dc_req); end
      n_checks++; if (dcif.dc_addr !== 64'h4000 + 64'(j * 8) || dcif.dc_we !== 1'b1) begin n_fail++; $display("FAIL drain_addr[%0d]: got %h we=%b expected %h we=1", j, dcif.dc_addr, dcif.dc_we, 64'h4000 + 64'(j * 8)); end
      n_checks++; if (dcif.dc_wdata !== (64'hA0A0_0000_0000_0000 | 64'(j))) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", j, dcif.dc_wdata, 64'hA0A0_0000_0000_0000 | 64'(j)); end
      dcif.dc_done = 1'b1;
      tick(); dcif.dc_done = 1'b0;
      $display("drain[%0d] addr=%h", j, dcif.dc_addr);
    end
    tick(); tick();
    n_checks++; if (dcif.dc_req !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", dcif.dc_req); end
  endtask

  task automatic test_forward();
    drive_uop(2'd2, 64'h2000, 2'd3, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 128'h0);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_store_ready: got %b expected 1", in_ready); end
    tick();
    drive_uop(2'd1, 64'h2004, 2'd1, 1'b0, 64'h0, 128'h0);
    #1;
`ifdef MEM_STORE_FWD_EN
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_load_ready: got %b expected 1", in_ready); end
    tick(); drop_uop();
    n_checks++; if (out_valid !== 1'b1 || out_result !== 128'hBEEF) begin n_fail++; $display("FAIL fwd_result: got valid=%b result=%h expected 1 beef", out_valid, out_result); end
    n_checks++; if (dcif.dc_req === 1'b1 && dcif.dc_we !== 1'b1) begin n_fail++; $display("FAIL fwd_no_read: got req=%b we=%b expected no read", dcif.dc_req, dcif.dc_we); end
    dcif.dc_done = 1'b1;
    tick(); dcif.dc_done = 1'b0;
`else
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL nofwd_load_wait: got %b expected 0", in_ready); end
    tick();
    n_checks++; if (dcif.dc_req !== 1'b1 || dcif.dc_we !== 1'b1 || dcif.dc_addr !== 64'h2000) begin n_fail++; $display("FAIL nofwd_drain: got req=%b we=%b addr=%h expected 1 1 2000", dcif.dc_req, dcif.dc_we, dcif.dc_addr); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL nofwd_drain_ready: got %b expected 0", in_ready); end
    dcif.dc_done = 1'b1;
    tick(); dcif.dc_done = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || dcif.dc_req !== 1'b0) begin n_fail++; $display("FAIL nofwd_after_drain: got ready=%b req=%b expected 1 0", in_ready, dcif.dc_req); end
    tick(); drop_uop();
    n_checks++; if (dcif.dc_req !== 1'b1 || dcif.dc_we !== 1'b0 || dcif.dc_addr !== 64'h2000) begin n_fail++; $display("FAIL nofwd_read: got req=%b we=%b addr=%h expected 1 0 2000", dcif.dc_req, dcif.dc_we, dcif.dc_addr); end
    dcif.dc_rdata = 64'hDEAD_BEEF_CAFE_F00D; dcif.dc_done = 1'b1;
    tick(); dcif.dc_done = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_result !== 128'hBEEF) begin n_fail++; $display("FAIL nofwd_result: got valid=%b result=%h expected 1 beef", out_valid, out_result); end
`endif
    $display("forward load addr=2004 result=%h", out_result);
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive_uop(2'd2, 64'h5000 + 64'(i * 8), 2'd3, 1'b0, 64'(i + 7), 128'h0);
      tick();
    end
    drop_uop();
    dcif.dc_done = 1'b1;
    tick(); dcif.dc_done = 1'b0;
    drive_uop(2'd1, 64'h6000, 2'd3, 1'b0, 64'h0, 128'h0);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_load_ready: got %b expected 1", in_ready); end
    tick(); drop_uop();
    n_checks++; if (dcif.dc_req !== 1'b1 || dcif.dc_we !== 1'b0 || dcif.dc_addr !== 64'h6000) begin n_fail++; $display("FAIL rmid_load_req: got req=%b we=%b addr=%h expected 1 0 6000", dcif.dc_req, dcif.dc_we, dcif.dc_addr); end
    reset = 1'b1;
    tick(); reset = 1'b0;
    n_checks++; if (dcif.dc_req !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_after_reset: got req=%b ready=%b expected 0 1", dcif.dc_req, in_ready); end
    tick(); tick(); tick();
    n_checks++; if (dcif.dc_req !== 1'b0) begin n_fail++; $display("FAIL rmid_buffer_empty: got req=%b expected 0", dcif.dc_req); end
    dcif.dc_done = 1'b1;
    tick(); dcif.dc_done = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stray_done: got %b expected 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stray_done2: got %b expected 0", out_valid); end
    $display("reset mid-load: done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_load();
    test_misalign();
    test_sb_full();
    test_forward();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
